knn_vote: RTL and testbench

Majority-vote classifier stage directly downstream of the KNN distance sorter. After the sorter finishes a pass, it walks the sorter's K nearest-neighbour indices through the sorter's index-select port, fetches each neighbour's class label from a label memory, and tallies votes per class. It then outputs the winning class with a deterministic tie-break. It sits between the sorter and the software-visible result registers.

---
 rtl/knn_pkg.sv | 19 +
 rtl/knn_vote_cnt.sv | 39 +++
 rtl/knn_vote.sv | 130 +++++++++++++
 tb/tb_knn_vote.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// ---------------------------------------------------------------------------
// knn_pkg -- shared KNN sizing constants and vote FSM encoding.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package knn_pkg;
  localparam int K      = 4;
  localparam int IDX_W  = 8;
  localparam int LBL_W  = 3;
  localparam int NCLASS = 1 << LBL_W;

  localparam logic [2:0] KV_IDLE  = 3'd0;
  localparam logic [2:0] KV_FETCH = 3'd1;
  localparam logic [2:0] KV_DRAIN = 3'd2;
  localparam logic [2:0] KV_SCAN  = 3'd3;
  localparam logic [2:0] KV_DONE  = 3'd4;
endpackage

`default_nettype wire

// File: rtl/knn_vote_cnt.sv
// ---------------------------------------------------------------------------
// knn_vote_cnt -- bank of per-class saturating vote counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module knn_vote_cnt #(
  parameter int K     = knn_pkg::K,
  parameter int LBL_W = knn_pkg::LBL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_en,
  input  logic [LBL_W-1:0] inc_cls,
  input  logic [LBL_W-1:0] rd_cls,
  output logic [2:0]       rd_cnt
);
  import knn_pkg::*;

  localparam int NCL = 2 ** LBL_W;

  logic [2:0] cnt [NCL];

  generate
    for (genvar g = 0; g < NCL; g++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          cnt[g] <= 3'd0;
        end else if (inc_en && (inc_cls == LBL_W'(g)) && (cnt[g] != 3'(K))) begin
          cnt[g] <= cnt[g] + 3'd1;
        end
      end
    end
  endgenerate

  assign rd_cnt = cnt[rd_cls];
endmodule

`default_nettype wire

// File: rtl/knn_vote.sv
// ---------------------------------------------------------------------------
// knn_vote -- majority vote over the K nearest neighbours, nearest wins ties.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module knn_vote #(
  parameter int K     = knn_pkg::K,
  parameter int IDX_W = knn_pkg::IDX_W,
  parameter int LBL_W = knn_pkg::LBL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       n_valid,
  output logic [1:0]       sel,
  input  logic [IDX_W-1:0] idx_in,
  output logic             lbl_rd,
  output logic [IDX_W-1:0] lbl_addr,
  input  logic [LBL_W-1:0] lbl_data,
  output logic             busy,
  output logic             done,
  output logic [LBL_W-1:0] label_out,
  output logic [2:0]       votes_out
);
  import knn_pkg::*;

  logic [2:0]       state;
  logic [2:0]       nv;
  logic             rd_q;
  logic             got0;
  logic [LBL_W-1:0] lbl0;
  logic [LBL_W-1:0] best;
  logic [2:0]       best_cnt;
  logic [LBL_W-1:0] c;
  logic [2:0]       rd_cnt;
  logic [2:0]       nv_clamp;
  logic             take;
  logic [LBL_W-1:0] best_nxt;
  logic [2:0]       cnt_nxt;
  logic             accept;

  assign accept   = (state == KV_IDLE) && start;
  assign nv_clamp = (n_valid > 3'(K)) ? 3'(K) : n_valid;
  assign lbl_rd   = (state == KV_FETCH);
  assign lbl_addr = lbl_rd ? idx_in : '0;
  assign busy     = (state != KV_IDLE);
  assign done     = (state == KV_DONE);

  knn_vote_cnt #(.K(K), .LBL_W(LBL_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .inc_en  (rd_q),
    .inc_cls (lbl_data),
    .rd_cls  (c),
    .rd_cnt  (rd_cnt)
  );

  // Running maximum with one read port: lbl0 also wins on an equal count, so the
  // result matches "start at lbl0, replace only on strictly greater".
  always_comb begin
    take     = (rd_cnt > best_cnt) || ((rd_cnt == best_cnt) && (c == lbl0));
    best_nxt = take ? c : best;
    cnt_nxt  = take ? rd_cnt : best_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= KV_IDLE;
      nv        <= 3'd0;
      sel       <= 2'd0;
      rd_q      <= 1'b0;
      got0      <= 1'b0;
      lbl0      <= '0;
      best      <= '0;
      best_cnt  <= 3'd0;
      c         <= '0;
      label_out <= '0;
      votes_out <= 3'd0;
    end else begin
      rd_q <= lbl_rd;
      if (rd_q && !got0) begin
        lbl0 <= lbl_data;
        got0 <= 1'b1;
      end
      case (state)
        KV_IDLE: begin
          if (start) begin
            nv        <= nv_clamp;
            sel       <= 2'd0;
            got0      <= 1'b0;
            label_out <= '0;
            votes_out <= 3'd0;
            state     <= (nv_clamp == 3'd0) ? KV_DONE : KV_FETCH;
          end
        end
        KV_FETCH: begin
          if ({1'b0, sel} == nv - 3'd1) begin
            sel   <= 2'd0;
            state <= KV_DRAIN;
          end else begin
            sel <= sel + 2'd1;
          end
        end
        KV_DRAIN: begin
          // With a single neighbour its label is only arriving now.
          best     <= (rd_q && !got0) ? lbl_data : lbl0;
          best_cnt <= 3'd0;
          c        <= '0;
          state    <= KV_SCAN;
        end
        KV_SCAN: begin
          best     <= best_nxt;
          best_cnt <= cnt_nxt;
          c        <= c + 1'b1;
          if (c == {LBL_W{1'b1}}) begin
            label_out <= best_nxt;
            votes_out <= cnt_nxt;
            state     <= KV_DONE;
          end
        end
        KV_DONE: state <= KV_IDLE;
        default: state <= KV_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_knn_vote.sv
// ---------------------------------------------------------------------------
// tb_knn_vote -- directed self-checking bench for knn_vote.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_knn_vote;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] n_valid = 3'd0;
  logic [1:0] sel;
  logic [7:0] idx_in;
  logic       lbl_rd;
  logic [7:0] lbl_addr;
  logic [2:0] lbl_data = 3'd0;
  logic       busy;
  logic       done;
  logic [2:0] label_out;
  logic [2:0] votes_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] idx_tbl [4];
  logic [2:0] lbl_mem [256];

  always #5 clk = ~clk;

  // Sorter index output and label memory models.
  assign idx_in = idx_tbl[sel];
  always_ff @(posedge clk) if (lbl_rd) lbl_data <= lbl_mem[lbl_addr];

  knn_vote dut (
    .clk(clk), .rst(rst), .start(start), .n_valid(n_valid), .sel(sel),
    .idx_in(idx_in), .lbl_rd(lbl_rd), .lbl_addr(lbl_addr), .lbl_data(lbl_data),
    .busy(busy), .done(done), .label_out(label_out), .votes_out(votes_out)
  );

  task automatic run_vote(input logic [2:0] l0, input logic [2:0] l1,
                          input logic [2:0] l2, input logic [2:0] l3,
                          input logic [2:0] nv, input int glitch,
                          output int cyc, output int reads);
    lbl_mem[idx_tbl[0]] = l0;
    lbl_mem[idx_tbl[1]] = l1;
    lbl_mem[idx_tbl[2]] = l2;
    lbl_mem[idx_tbl[3]] = l3;
    @(negedge clk);
    start   = 1'b1;
    n_valid = nv;
    @(posedge clk);
    #1 start = 1'b0;
    n_valid = 3'd1;
    cyc   = 0;
    reads = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (lbl_rd) reads++;
      start = (cyc == glitch);
      if (done) break;
    end
    if (start) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sel, lbl_rd, lbl_addr, busy, done, label_out, votes_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%0d rd=%0d addr=%0d busy=%0d done=%0d lbl=%0d votes=%0d, want all 0",
               sel, lbl_rd, lbl_addr, busy, done, label_out, votes_out);
    end
  endtask

  task automatic test_majority();
    int cyc, reads;
    run_vote(3'd2, 3'd5, 3'd2, 3'd2, 3'd4, -1, cyc, reads);
    checks++;
    if (cyc !== 14) begin errors++; $display("FAIL maj_latency: got %0d want 14", cyc); end
    checks++;
    if (reads !== 4) begin errors++; $display("FAIL maj_reads: got %0d want 4", reads); end
    checks++;
    if (label_out !== 3'd2 || votes_out !== 3'd3) begin
      errors++; $display("FAIL maj_result: got %0d/%0d want 2/3", label_out, votes_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || label_out !== 3'd2) begin
      errors++; $display("FAIL maj_after_done: got done=%0d busy=%0d lbl=%0d want 0/0/2", done, busy, label_out);
    end
  endtask

  task automatic test_tie();
    int cyc, reads;
    run_vote(3'd6, 3'd1, 3'd1, 3'd6, 3'd4, -1, cyc, reads);
    checks++;
    if (label_out !== 3'd6 || votes_out !== 3'd2) begin
      errors++; $display("FAIL tie_a: got %0d/%0d want 6/2", label_out, votes_out);
    end
    run_vote(3'd1, 3'd6, 3'd6, 3'd1, 3'd4, -1, cyc, reads);
    checks++;
    if (label_out !== 3'd1 || votes_out !== 3'd2) begin
      errors++; $display("FAIL tie_b: got %0d/%0d want 1/2", label_out, votes_out);
    end
  endtask

  task automatic test_distinct();
    int cyc, reads;
    run_vote(3'd7, 3'd3, 3'd0, 3'd4, 3'd4, -1, cyc, reads);
    checks++;
    if (label_out !== 3'd7 || votes_out !== 3'd1) begin
      errors++; $display("FAIL distinct: got %0d/%0d want 7/1", label_out, votes_out);
    end
  endtask

  task automatic test_partial_empty();
    int cyc, reads;
    run_vote(3'd3, 3'd4, 3'd4, 3'd4, 3'd2, -1, cyc, reads);
    checks++;
    if (cyc !== 12 || reads !== 2) begin
      errors++; $display("FAIL partial_timing: got cyc=%0d reads=%0d want 12/2", cyc, reads);
    end
    checks++;
    if (label_out !== 3'd3 || votes_out !== 3'd1) begin
      errors++; $display("FAIL partial_result: got %0d/%0d want 3/1", label_out, votes_out);
    end
    run_vote(3'd5, 3'd5, 3'd5, 3'd5, 3'd0, -1, cyc, reads);
    checks++;
    if (cyc !== 1 || reads !== 0) begin
      errors++; $display("FAIL empty_timing: got cyc=%0d reads=%0d want 1/0", cyc, reads);
    end
    checks++;
    if (label_out !== 3'd0 || votes_out !== 3'd0) begin
      errors++; $display("FAIL empty_result: got %0d/%0d want 0/0", label_out, votes_out);
    end
    run_vote(3'd5, 3'd5, 3'd1, 3'd2, 3'd7, -1, cyc, reads);
    checks++;
    if (cyc !== 14 || reads !== 4 || label_out !== 3'd5 || votes_out !== 3'd2) begin
      errors++; $display("FAIL clamp: got cyc=%0d reads=%0d res=%0d/%0d want 14/4 5/2",
                         cyc, reads, label_out, votes_out);
    end
  endtask

  task automatic test_reset_busy();
    int cyc, reads;
    lbl_mem[idx_tbl[0]] = 3'd4;
    lbl_mem[idx_tbl[1]] = 3'd4;
    lbl_mem[idx_tbl[2]] = 3'd4;
    lbl_mem[idx_tbl[3]] = 3'd4;
    @(negedge clk);
    start = 1'b1; n_valid = 3'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({sel, lbl_rd, lbl_addr, busy, done, label_out, votes_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid: got sel=%0d rd=%0d addr=%0d busy=%0d done=%0d lbl=%0d votes=%0d, want all 0",
               sel, lbl_rd, lbl_addr, busy, done, label_out, votes_out);
    end
    rst = 1'b0;
    run_vote(3'd0, 3'd2, 3'd0, 3'd1, 3'd4, -1, cyc, reads);
    checks++;
    if (label_out !== 3'd0 || votes_out !== 3'd2) begin
      errors++; $display("FAIL after_reset: got %0d/%0d want 0/2", label_out, votes_out);
    end
    run_vote(3'd3, 3'd6, 3'd6, 3'd5, 3'd4, 2, cyc, reads);
    checks++;
    if (cyc !== 14 || reads !== 4 || label_out !== 3'd6 || votes_out !== 3'd2) begin
      errors++; $display("FAIL start_in_fetch: got cyc=%0d reads=%0d res=%0d/%0d want 14/4 6/2",
                         cyc, reads, label_out, votes_out);
    end
    run_vote(3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 14, cyc, reads);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || label_out !== 3'd1 || votes_out !== 3'd4) begin
      errors++; $display("FAIL start_at_done: got busy=%0d res=%0d/%0d want 0 1/4", busy, label_out, votes_out);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, reads;
    run_vote(3'd2, 3'd2, 3'd2, 3'd2, 3'd4, -1, cyc, reads);
    checks++;
    if (label_out !== 3'd2 || votes_out !== 3'd4) begin
      errors++; $display("FAIL b2b_first: got %0d/%0d want 2/4", label_out, votes_out);
    end
    run_vote(3'd3, 3'd1, 3'd3, 3'd0, 3'd4, -1, cyc, reads);
    checks++;
    if (cyc !== 14 || label_out !== 3'd3 || votes_out !== 3'd2) begin
      errors++; $display("FAIL b2b_second: got cyc=%0d res=%0d/%0d want 14 3/2", cyc, label_out, votes_out);
    end
  endtask

  initial begin
    idx_tbl[0] = 8'd10;
    idx_tbl[1] = 8'd20;
    idx_tbl[2] = 8'd30;
    idx_tbl[3] = 8'd40;
    for (int i = 0; i < 256; i++) lbl_mem[i] = 3'd0;
    test_reset();
    test_majority();
    test_tie();
    test_distinct();
    test_partial_empty();
    test_reset_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
